// File: rtl/ft_error_monitor.sv
// Lockstep error monitor: counts ftm divergences, logs both PCs,
// requests recovery and halts once the error budget is spent.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   error_i                ftm error level
//   pc_0_i, pc_1_i         core PCs sampled on an error edge
//   recover_req_o/ack_i    recovery request handshake
//   halt_o                 sticky budget-exhausted flag
//   err_count_o            saturating error event count
//   log_valid_o/pc_o/ready_i  PC log FIFO head and pop
//   log_ovf_o              sticky dropped-entry flag
module ft_error_monitor #(
  parameter int unsigned ERR_THRESHOLD = 20,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned LOG_DEPTH     = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             error_i,
  input  logic [31:0]      pc_0_i,
  input  logic [31:0]      pc_1_i,
  output logic             recover_req_o,
  input  logic             recover_ack_i,
  output logic             halt_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             log_valid_o,
  output logic [64:0]      log_pc_o,
  input  logic             log_ready_i,
  output logic             log_ovf_o
);

  localparam int unsigned AW = $clog2(LOG_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR = CNT_W'(ERR_THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECOVER,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic             err_q;
  logic             evt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             thr_hit;

  logic [64:0]      mem [LOG_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             ovf_q;

  assign evt     = error_i & ~err_q;
  assign cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign thr_hit = cnt_nxt >= THR;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & log_ready_i;
  // A pop in the same cycle frees the slot for the incoming entry.
  assign push  = evt & (~full | pop);
  assign drop  = evt & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      err_q   <= error_i;
      state_q <= state_d;
      if (evt) cnt_q <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {pc_0_i != pc_1_i, pc_1_i, pc_0_i};
  end

  always_comb begin
    state_d       = state_q;
    recover_req_o = 1'b0;
    halt_o        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (evt) state_d = thr_hit ? S_HALT : S_RECOVER;
      end
      S_RECOVER: begin
        recover_req_o = 1'b1;
        if (evt && thr_hit) state_d = S_HALT;
        else if (recover_ack_i) state_d = S_IDLE;
      end
      S_HALT: begin
        halt_o = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_count_o = cnt_q;
  assign log_valid_o = ~empty;
  // Gated so the head reads zero out of reset instead of stale storage.
  assign log_pc_o    = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign log_ovf_o   = ovf_q;

endmodule

// File: tb/tb_ft_error_monitor.sv
// Scoreboard bench for ft_error_monitor: a queue-based reference
// model predicts each cycle's outputs, a monitor compares them.
module tb_ft_error_monitor;

  localparam int TH   = 5;
  localparam int CW   = 3;
  localparam int LD   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 0;
  logic          rst_ni = 0;
  logic          error_i = 0;
  logic [31:0]   pc_0_i = 0;
  logic [31:0]   pc_1_i = 0;
  logic          recover_req_o;
  logic          recover_ack_i = 0;
  logic          halt_o;
  logic [CW-1:0] err_count_o;
  logic          log_valid_o;
  logic [64:0]   log_pc_o;
  logic          log_ready_i = 0;
  logic          log_ovf_o;

  ft_error_monitor #(
    .ERR_THRESHOLD(TH),
    .CNT_W(CW),
    .LOG_DEPTH(LD)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .error_i(error_i),
    .pc_0_i(pc_0_i),
    .pc_1_i(pc_1_i),
    .recover_req_o(recover_req_o),
    .recover_ack_i(recover_ack_i),
    .halt_o(halt_o),
    .err_count_o(err_count_o),
    .log_valid_o(log_valid_o),
    .log_pc_o(log_pc_o),
    .log_ready_i(log_ready_i),
    .log_ovf_o(log_ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    bit          halt;
    bit          valid;
    bit          ovf;
    int          cnt;
    logic [64:0] head;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int          m_cnt;
  bit          m_req, m_halt, m_ovf, m_prev;
  logic [64:0] m_log[$];

  function automatic void chk(string nm, logic [64:0] act,
                              logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    m_cnt = 0;
    m_req = 0;
    m_halt = 0;
    m_ovf = 0;
    m_prev = 0;
    m_log.delete();
  endfunction

  function automatic void model(bit e, logic [31:0] p0, logic [31:0] p1,
                                bit a, bit r);
    exp_t x;
    bit evt, pop;
    evt = e && !m_prev;
    m_prev = e;
    pop = (m_log.size() != 0) && r;
    if (pop) void'(m_log.pop_front());
    if (evt) begin
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (m_log.size() < LD) m_log.push_back({p0 != p1, p1, p0});
      else m_ovf = 1;
    end
    if (!m_halt) begin
      if (evt && m_cnt >= TH) begin
        m_halt = 1;
        m_req = 0;
      end else if (m_req) begin
        if (a) m_req = 0;
      end else if (evt) begin
        m_req = 1;
      end
    end
    x.req = m_req;
    x.halt = m_halt;
    x.valid = m_log.size() != 0;
    x.ovf = m_ovf;
    x.cnt = m_cnt;
    x.head = (m_log.size() != 0) ? m_log[0] : 65'd0;
    exp_q.push_back(x);
  endfunction

  task automatic cyc(bit e, logic [31:0] p0, logic [31:0] p1,
                     bit a, bit r);
    @(negedge clk);
    rst_ni = 1;
    error_i = e;
    pc_0_i = p0;
    pc_1_i = p1;
    recover_ack_i = a;
    log_ready_i = r;
    model(e, p0, p1, a, r);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_req"}, 65'(recover_req_o), 65'd0);
    chk({nm, "_halt"}, 65'(halt_o), 65'd0);
    chk({nm, "_cnt"}, 65'(err_count_o), 65'd0);
    chk({nm, "_valid"}, 65'(log_valid_o), 65'd0);
    chk({nm, "_pc"}, log_pc_o, 65'd0);
    chk({nm, "_ovf"}, 65'(log_ovf_o), 65'd0);
  endtask

  // Reset mid-cycle, away from any clock edge.
  task automatic rst_mid();
    @(negedge clk);
    #2;
    rst_ni = 0;
    error_i = 0;
    recover_ack_i = 0;
    log_ready_i = 0;
    #1;
    chk_zero("async_rst");
    m_reset();
    model(0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("req", 65'(recover_req_o), 65'(x.req));
        chk("halt", 65'(halt_o), 65'(x.halt));
        chk("count", 65'(err_count_o), 65'(x.cnt));
        chk("valid", 65'(log_valid_o), 65'(x.valid));
        chk("head", log_pc_o, x.head);
        chk("ovf", 65'(log_ovf_o), 65'(x.ovf));
      end
    end
  end

  initial begin : stim
    bit          lvl;
    logic [31:0] p0, p1;
    m_reset();
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);

    // single held error, equal PCs
    repeat (3) cyc(1, 32'h40, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // second edge while request pending, mismatching PCs
    cyc(1, 32'h44, 32'h48, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1);

    // overflow and threshold halt
    rst_mid();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h100 + i * 4, 32'h200 + i * 4, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    repeat (2) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h300, 32'h300, 1, 0);
      cyc(0, 0, 0, 0, 0);
    end
    repeat (5) cyc(0, 0, 0, 0, 1);

    // full FIFO popped while a new event arrives
    rst_mid();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h500 + i, 32'h500 + i, 1, 0);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(1, 32'h600, 32'h604, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 1);

    // reset mid-RECOVER with log non-empty
    rst_mid();
    cyc(1, 32'h10, 32'h10, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    rst_mid();
    cyc(0, 0, 0, 0, 0);

    // randomized traffic
    lvl = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_mid();
        lvl = 0;
      end else begin
        if ($urandom_range(0, 2) == 0) lvl = ~lvl;
        p0 = 32'h100 + 4 * $urandom_range(0, 3);
        p1 = ($urandom_range(0, 1) == 0) ? p0
           : 32'h100 + 4 * $urandom_range(0, 3);
        cyc(lvl, p0, p1, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0);
      end
    end

    repeat (3) @(negedge clk);
    chk("drain", 65'(exp_q.size()), 65'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
